// File: rtl/carpma_denetleyici.sv
// carpma_denetleyici
//   Issue/retire controller for the 3-stage 32x32 multiplier used by
//   RV32M MUL/MULH/MULHSU/MULHU. Operands are taken from execute through
//   a valid/ready handshake and forwarded to the multiplier, which cannot
//   stall. A shadow pipeline tracks every issued op. When an op leaves the
//   shadow pipeline, the selected half of the product is written into a
//   result FIFO. Writeback drains the FIFO through a valid/ready handshake.
//
// Ports
//   clk_i, rst_i           clock, asynchronous active-high reset
//   islem_gecerli_i/hazir_o upstream handshake
//   islec0_i, islec1_i     rs1 / rs2 operands
//   islem_kodu_i           00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   etiket_i               destination tag carried with the op
//   temizle_i              flush of all accepted, unretired ops
//   carpici_*_o            operands, signedness and valid to the multiplier
//   carpim_i, carpim_gecerli_i  product and valid from the multiplier
//   sonuc_gecerli_o/hazir_i writeback handshake
//   sonuc_o, sonuc_etiket_o FIFO head word and its tag
//   hata_o                 sticky: multiplier valid disagreed with shadow pipe
module carpma_denetleyici #(
  parameter int CARPICI_GECIKME = 3,
  parameter int FIFO_DERINLIK   = 8,
  parameter int ETIKET_GENISLIK = 5
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       islem_gecerli_i,
  output logic                       islem_hazir_o,
  input  logic [31:0]                islec0_i,
  input  logic [31:0]                islec1_i,
  input  logic [1:0]                 islem_kodu_i,
  input  logic [ETIKET_GENISLIK-1:0] etiket_i,
  input  logic                       temizle_i,
  output logic [31:0]                carpici_islec0_o,
  output logic [31:0]                carpici_islec1_o,
  output logic                       carpici_isaret0_o,
  output logic                       carpici_isaret1_o,
  output logic                       carpici_gecerli_o,
  input  logic [63:0]                carpim_i,
  input  logic                       carpim_gecerli_i,
  output logic                       sonuc_gecerli_o,
  input  logic                       sonuc_hazir_i,
  output logic [31:0]                sonuc_o,
  output logic [ETIKET_GENISLIK-1:0] sonuc_etiket_o,
  output logic                       hata_o
);

  localparam int SAYAC_W   = $clog2(FIFO_DERINLIK + 1);
  localparam int PTR_W     = (FIFO_DERINLIK > 1) ? $clog2(FIFO_DERINLIK) : 1;
  localparam int PENCERE_W = $clog2(CARPICI_GECIKME + 1);
  localparam int SON       = CARPICI_GECIKME - 1;

  logic [SAYAC_W-1:0] ucusta, doluluk;
  logic [SAYAC_W:0]   toplam;
  logic               kabul, yaz, oku;

  // Credit uses registered counts only, so ready never depends on sonuc_hazir_i.
  assign toplam        = {1'b0, ucusta} + {1'b0, doluluk};
  assign islem_hazir_o = (toplam < (SAYAC_W + 1)'(FIFO_DERINLIK));
  assign kabul         = islem_gecerli_i && islem_hazir_o && !temizle_i;

  assign carpici_islec0_o  = islec0_i;
  assign carpici_islec1_o  = islec1_i;
  assign carpici_isaret0_o = (islem_kodu_i == 2'b01) || (islem_kodu_i == 2'b10);
  assign carpici_isaret1_o = (islem_kodu_i == 2'b01);
  assign carpici_gecerli_o = kabul;

  // golge_gecerli is killed by flush; golge_carpici mirrors what the
  // multiplier really has in flight and is never killed, so the hata_o
  // comparison stays exact across flushes.
  logic [CARPICI_GECIKME-1:0] golge_gecerli, golge_ust, golge_carpici;
  logic [ETIKET_GENISLIK-1:0] golge_etiket [CARPICI_GECIKME];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      golge_gecerli <= '0;
      golge_ust     <= '0;
      golge_carpici <= '0;
      for (int i = 0; i < CARPICI_GECIKME; i++) golge_etiket[i] <= '0;
    end else begin
      golge_gecerli[0] <= kabul;
      golge_carpici[0] <= kabul;
      golge_ust[0]     <= (islem_kodu_i != 2'b00);
      golge_etiket[0]  <= etiket_i;
      for (int i = 1; i < CARPICI_GECIKME; i++) begin
        golge_gecerli[i] <= temizle_i ? 1'b0 : golge_gecerli[i-1];
        golge_carpici[i] <= golge_carpici[i-1];
        golge_ust[i]     <= golge_ust[i-1];
        golge_etiket[i]  <= golge_etiket[i-1];
      end
    end
  end

  assign yaz = golge_gecerli[SON] && !temizle_i;
  assign oku = sonuc_gecerli_o && sonuc_hazir_i && !temizle_i;

  logic [31:0]                fifo_veri   [FIFO_DERINLIK];
  logic [ETIKET_GENISLIK-1:0] fifo_etiket [FIFO_DERINLIK];
  logic [PTR_W-1:0]           yaz_ptr, oku_ptr;
  logic [31:0]                secilen;

  assign secilen = golge_ust[SON] ? carpim_i[63:32] : carpim_i[31:0];

  function automatic logic [PTR_W-1:0] ptr_art(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DERINLIK - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ucusta  <= '0;
      doluluk <= '0;
      yaz_ptr <= '0;
      oku_ptr <= '0;
    end else if (temizle_i) begin
      ucusta  <= '0;
      doluluk <= '0;
      yaz_ptr <= '0;
      oku_ptr <= '0;
    end else begin
      ucusta  <= ucusta + SAYAC_W'(kabul) - SAYAC_W'(golge_gecerli[SON]);
      doluluk <= doluluk + SAYAC_W'(yaz) - SAYAC_W'(oku);
      if (yaz) yaz_ptr <= ptr_art(yaz_ptr);
      if (oku) oku_ptr <= ptr_art(oku_ptr);
    end
  end

  // Storage needs no reset: entries are only visible while doluluk != 0.
  always_ff @(posedge clk_i) begin
    if (yaz) begin
      fifo_veri[yaz_ptr]   <= secilen;
      fifo_etiket[yaz_ptr] <= golge_etiket[SON];
    end
  end

  assign sonuc_gecerli_o = (doluluk != '0);
  assign sonuc_o         = sonuc_gecerli_o ? fifo_veri[oku_ptr] : '0;
  assign sonuc_etiket_o  = sonuc_gecerli_o ? fifo_etiket[oku_ptr] : '0;

  // The multiplier has no reset; products of ops issued before reset can
  // still emerge during the first CARPICI_GECIKME cycles, so the check
  // stays disabled until the shadow pipe has refilled.
  logic [PENCERE_W-1:0] pencere;
  logic                 pencere_acik;

  assign pencere_acik = (pencere == PENCERE_W'(CARPICI_GECIKME));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pencere <= '0;
      hata_o  <= 1'b0;
    end else begin
      if (!pencere_acik) pencere <= pencere + PENCERE_W'(1);
      if (pencere_acik && (carpim_gecerli_i != golge_carpici[SON])) hata_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_carpma_denetleyici.sv
module tb_carpma_denetleyici;

  logic        clk = 1'b0;
  logic        rst;
  logic        islem_gecerli, temizle, sonuc_hazir;
  logic [31:0] islec0, islec1;
  logic [1:0]  kod;
  logic [4:0]  etiket;
  logic        islem_hazir;
  logic [31:0] c_islec0, c_islec1;
  logic        c_isaret0, c_isaret1, c_gecerli;
  logic [63:0] carpim;
  logic        carpim_gecerli;
  logic        sonuc_gecerli;
  logic [31:0] sonuc;
  logic [4:0]  sonuc_etiket;
  logic        hata;

  int checks = 0;
  int passed = 0;

  logic [36:0] bek_q[$];

  // Multiplier model: 3 stages, no reset; sahte injects a spurious valid.
  logic [63:0] m_p [3];
  logic [2:0]  m_v;
  logic        sahte;

  always #5 clk = ~clk;

  carpma_denetleyici dut (
    .clk_i(clk), .rst_i(rst),
    .islem_gecerli_i(islem_gecerli), .islem_hazir_o(islem_hazir),
    .islec0_i(islec0), .islec1_i(islec1), .islem_kodu_i(kod), .etiket_i(etiket),
    .temizle_i(temizle),
    .carpici_islec0_o(c_islec0), .carpici_islec1_o(c_islec1),
    .carpici_isaret0_o(c_isaret0), .carpici_isaret1_o(c_isaret1),
    .carpici_gecerli_o(c_gecerli),
    .carpim_i(carpim), .carpim_gecerli_i(carpim_gecerli),
    .sonuc_gecerli_o(sonuc_gecerli), .sonuc_hazir_i(sonuc_hazir),
    .sonuc_o(sonuc), .sonuc_etiket_o(sonuc_etiket), .hata_o(hata)
  );

  function automatic logic [63:0] carp(input logic [31:0] a, input logic [31:0] b,
                                       input logic sa, input logic sb);
    logic signed [65:0] x, y, p;
    x = sa ? {{34{a[31]}}, a} : {34'd0, a};
    y = sb ? {{34{b[31]}}, b} : {34'd0, b};
    p = x * y;
    return p[63:0];
  endfunction

  function automatic logic [31:0] ref_sonuc(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] k);
    logic [63:0] p;
    p = carp(a, b, (k == 2'b01) || (k == 2'b10), (k == 2'b01));
    return (k == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  initial begin
    m_v = '0;
    for (int i = 0; i < 3; i++) m_p[i] = '0;
  end

  always @(posedge clk) begin
    m_v    <= {m_v[1:0], c_gecerli};
    m_p[0] <= carp(c_islec0, c_islec1, c_isaret0, c_isaret1);
    m_p[1] <= m_p[0];
    m_p[2] <= m_p[1];
  end

  assign carpim         = m_p[2];
  assign carpim_gecerli = m_v[2] | sahte;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (islem_hazir !== 1'b1 || sonuc_gecerli !== 1'b0 || sonuc !== 32'h0 ||
        sonuc_etiket !== 5'h0 || hata !== 1'b0 || c_gecerli !== 1'b0)
      $display("FAIL reset: hazir=%b gecerli=%b sonuc=%h etiket=%h hata=%b cg=%b, required 1 0 0 0 0 0",
               islem_hazir, sonuc_gecerli, sonuc, sonuc_etiket, hata, c_gecerli);
    else passed++;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_tek_mul();
    islec0 = 32'h7; islec1 = 32'hFFFF_FFFD; kod = 2'b00; etiket = 5'd3; islem_gecerli = 1'b1;
    #1;
    checks++;
    if (c_gecerli !== 1'b1 || c_isaret0 !== 1'b0 || c_isaret1 !== 1'b0 ||
        c_islec0 !== 32'h7 || c_islec1 !== 32'hFFFF_FFFD)
      $display("FAIL mul_issue: g=%b s0=%b s1=%b a=%h b=%h, required 1 0 0 7 fffffffd",
               c_gecerli, c_isaret0, c_isaret1, c_islec0, c_islec1);
    else passed++;
    tick();
    islem_gecerli = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      checks++;
      if (sonuc_gecerli !== 1'b0)
        $display("FAIL mul_early: cycle +%0d gecerli=%b, required 0", k, sonuc_gecerli);
      else passed++;
      tick();
    end
    checks++;
    if (sonuc_gecerli !== 1'b1 || sonuc !== 32'hFFFF_FFEB || sonuc_etiket !== 5'd3)
      $display("FAIL mul_result: gecerli=%b sonuc=%h etiket=%0d, required 1 ffffffeb 3",
               sonuc_gecerli, sonuc, sonuc_etiket);
    else passed++;
    tick();
    checks++;
    if (sonuc_gecerli !== 1'b0)
      $display("FAIL mul_pop: gecerli=%b, required 0", sonuc_gecerli);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [1:0]  kodlar [3];
    logic [31:0] bek    [3];
    logic [1:0]  isaret [3];
    kodlar[0] = 2'b01; bek[0] = 32'h0000_0000; isaret[0] = 2'b11;
    kodlar[1] = 2'b10; bek[1] = 32'hFFFF_FFFF; isaret[1] = 2'b10;
    kodlar[2] = 2'b11; bek[2] = 32'hFFFF_FFFE; isaret[2] = 2'b00;
    for (int i = 0; i < 3; i++) begin
      islec0 = 32'hFFFF_FFFF; islec1 = 32'hFFFF_FFFF; kod = kodlar[i];
      etiket = 5'(10 + i); islem_gecerli = 1'b1;
      #1;
      checks++;
      if ({c_isaret0, c_isaret1} !== isaret[i] || c_gecerli !== 1'b1)
        $display("FAIL b2b_sign%0d: isaret=%b%b g=%b, required %b 1",
                 i, c_isaret0, c_isaret1, c_gecerli, isaret[i]);
      else passed++;
      tick();
    end
    islem_gecerli = 1'b0;
    checks++;
    if (sonuc_gecerli !== 1'b0)
      $display("FAIL b2b_early: gecerli=%b, required 0", sonuc_gecerli);
    else passed++;
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (sonuc_gecerli !== 1'b1 || sonuc !== bek[i] || sonuc_etiket !== 5'(10 + i))
        $display("FAIL b2b_result%0d: gecerli=%b sonuc=%h etiket=%0d, required 1 %h %0d",
                 i, sonuc_gecerli, sonuc, sonuc_etiket, bek[i], 10 + i);
      else passed++;
      tick();
    end
    checks++;
    if (sonuc_gecerli !== 1'b0)
      $display("FAIL b2b_drain: gecerli=%b, required 0", sonuc_gecerli);
    else passed++;
  endtask

  task automatic test_stall();
    int kabul_sayisi = 0;
    sonuc_hazir = 1'b0;
    for (int i = 0; i < 20; i++) begin
      islec0 = 32'(i + 1); islec1 = 32'd2; kod = 2'b00; etiket = 5'(i); islem_gecerli = 1'b1;
      if (islem_hazir === 1'b1) kabul_sayisi++;
      tick();
    end
    islem_gecerli = 1'b0;
    repeat (4) tick();
    checks++;
    if (kabul_sayisi != 8 || islem_hazir !== 1'b0)
      $display("FAIL stall_accept: accepted=%0d hazir=%b, required 8 0", kabul_sayisi, islem_hazir);
    else passed++;
    repeat (2) tick();
    checks++;
    if (sonuc_gecerli !== 1'b1 || sonuc !== 32'd2 || sonuc_etiket !== 5'd0)
      $display("FAIL stall_hold: gecerli=%b sonuc=%h etiket=%0d, required 1 2 0",
               sonuc_gecerli, sonuc, sonuc_etiket);
    else passed++;
    sonuc_hazir = 1'b1;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (sonuc_gecerli !== 1'b1 || sonuc !== 32'(2 * (k + 1)) || sonuc_etiket !== 5'(k))
        $display("FAIL stall_drain%0d: gecerli=%b sonuc=%0d etiket=%0d, required 1 %0d %0d",
                 k, sonuc_gecerli, sonuc, sonuc_etiket, 2 * (k + 1), k);
      else passed++;
      tick();
    end
    checks++;
    if (sonuc_gecerli !== 1'b0 || islem_hazir !== 1'b1)
      $display("FAIL stall_empty: gecerli=%b hazir=%b, required 0 1", sonuc_gecerli, islem_hazir);
    else passed++;
  endtask

  task automatic test_streaming();
    logic [36:0] bek;
    sonuc_hazir = 1'b1;
    for (int i = 0; i < 110; i++) begin
      if (sonuc_gecerli === 1'b1) begin
        checks++;
        if (bek_q.size() == 0) begin
          $display("FAIL stream_extra: sonuc=%h etiket=%0d, required no result", sonuc, sonuc_etiket);
        end else begin
          bek = bek_q.pop_front();
          if ({sonuc, sonuc_etiket} !== bek)
            $display("FAIL stream_result: sonuc=%h etiket=%0d, required %h %0d",
                     sonuc, sonuc_etiket, bek[36:5], bek[4:0]);
          else passed++;
        end
      end
      if (i < 100) begin
        checks++;
        if (islem_hazir !== 1'b1)
          $display("FAIL stream_ready: op %0d hazir=%b, required 1", i, islem_hazir);
        else passed++;
        islec0 = $urandom(); islec1 = $urandom(); kod = 2'($urandom_range(3));
        etiket = 5'($urandom_range(31)); islem_gecerli = 1'b1;
        bek_q.push_back({ref_sonuc(islec0, islec1, kod), etiket});
      end else begin
        islem_gecerli = 1'b0;
      end
      tick();
    end
    checks++;
    if (bek_q.size() != 0 || hata !== 1'b0 || sonuc_gecerli !== 1'b0)
      $display("FAIL stream_end: left=%0d hata=%b gecerli=%b, required 0 0 0",
               bek_q.size(), hata, sonuc_gecerli);
    else passed++;
    bek_q.delete();
  endtask

  task automatic test_flush();
    sonuc_hazir = 1'b0;
    for (int i = 0; i < 5; i++) begin
      islec0 = 32'(i + 3); islec1 = 32'd5; kod = 2'b00; etiket = 5'(20 + i); islem_gecerli = 1'b1;
      tick();
    end
    islem_gecerli = 1'b0;
    tick();
    checks++;
    if (sonuc_gecerli !== 1'b1 || sonuc !== 32'd15)
      $display("FAIL flush_pre: gecerli=%b sonuc=%0d, required 1 15", sonuc_gecerli, sonuc);
    else passed++;
    temizle = 1'b1; sonuc_hazir = 1'b1;
    islec0 = 32'd1; islec1 = 32'd1; etiket = 5'd30; islem_gecerli = 1'b1;
    #1;
    checks++;
    if (c_gecerli !== 1'b0)
      $display("FAIL flush_noaccept: carpici_gecerli=%b, required 0", c_gecerli);
    else passed++;
    tick();
    temizle = 1'b0; islem_gecerli = 1'b0;
    checks++;
    if (sonuc_gecerli !== 1'b0 || islem_hazir !== 1'b1)
      $display("FAIL flush_next: gecerli=%b hazir=%b, required 0 1", sonuc_gecerli, islem_hazir);
    else passed++;
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if (sonuc_gecerli !== 1'b0)
        $display("FAIL flush_stale: cycle %0d gecerli=%b sonuc=%h, required 0", k, sonuc_gecerli, sonuc);
      else passed++;
    end
    islec0 = 32'd9; islec1 = 32'd9; kod = 2'b00; etiket = 5'd7; islem_gecerli = 1'b1;
    tick();
    islem_gecerli = 1'b0;
    repeat (3) tick();
    checks++;
    if (sonuc_gecerli !== 1'b1 || sonuc !== 32'd81 || sonuc_etiket !== 5'd7)
      $display("FAIL flush_after: gecerli=%b sonuc=%0d etiket=%0d, required 1 81 7",
               sonuc_gecerli, sonuc, sonuc_etiket);
    else passed++;
    tick();
    checks++;
    if (sonuc_gecerli !== 1'b0 || hata !== 1'b0)
      $display("FAIL flush_end: gecerli=%b hata=%b, required 0 0", sonuc_gecerli, hata);
    else passed++;
  endtask

  task automatic test_reset_mid();
    sonuc_hazir = 1'b0;
    for (int i = 0; i < 4; i++) begin
      islec0 = 32'(i + 2); islec1 = 32'd3; kod = 2'b00; etiket = 5'(1 + i); islem_gecerli = 1'b1;
      tick();
    end
    islem_gecerli = 1'b0;
    checks++;
    if (sonuc_gecerli !== 1'b1)
      $display("FAIL rstmid_pre: gecerli=%b, required 1", sonuc_gecerli);
    else passed++;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (sonuc_gecerli !== 1'b0 || sonuc !== 32'h0 || sonuc_etiket !== 5'h0 ||
        islem_hazir !== 1'b1 || hata !== 1'b0)
      $display("FAIL rstmid_async: gecerli=%b sonuc=%h etiket=%0d hazir=%b hata=%b, required 0 0 0 1 0",
               sonuc_gecerli, sonuc, sonuc_etiket, islem_hazir, hata);
    else passed++;
    tick();
    rst = 1'b0;
    sonuc_hazir = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if (sonuc_gecerli !== 1'b0 || hata !== 1'b0)
        $display("FAIL rstmid_after: cycle %0d gecerli=%b hata=%b, required 0 0", k, sonuc_gecerli, hata);
      else passed++;
    end
  endtask

  task automatic test_hata();
    sahte = 1'b1;
    tick();
    sahte = 1'b0;
    checks++;
    if (hata !== 1'b1 || sonuc_gecerli !== 1'b0)
      $display("FAIL hata_set: hata=%b gecerli=%b, required 1 0", hata, sonuc_gecerli);
    else passed++;
    repeat (3) tick();
    checks++;
    if (hata !== 1'b1 || sonuc_gecerli !== 1'b0)
      $display("FAIL hata_sticky: hata=%b gecerli=%b, required 1 0", hata, sonuc_gecerli);
    else passed++;
    rst = 1'b1;
    #1;
    checks++;
    if (hata !== 1'b0)
      $display("FAIL hata_clear: hata=%b, required 0", hata);
    else passed++;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; islem_gecerli = 1'b0; temizle = 1'b0; sonuc_hazir = 1'b1; sahte = 1'b0;
    islec0 = '0; islec1 = '0; kod = '0; etiket = '0;
    test_reset();
    test_tek_mul();
    test_back_to_back();
    test_stall();
    test_streaming();
    test_flush();
    test_reset_mid();
    test_hata();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule
